// File: rtl/mult_seq_ctrl.sv
// Multi-cycle mult/multu sequencer: radix-2 shift-add over WIDTH iterations on
// operand magnitudes, followed by a single sign-correction step that writes the
// 2*WIDTH-bit product into the HI/LO result registers.
//
// Handshake: start_i is accepted only on an IDLE edge with flush_i low; busy_o
// is high while CALC or FIX is active and start_i is ignored during that time;
// done_o is a registered one-cycle pulse, from which hi_o/lo_o are valid and held
// until the next completion.
module mult_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             is_signed_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [1:0]       state_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;   // low product half shifts in here
  logic [WIDTH-1:0] acc_q, acc_d;         // upper product half
  logic             neg_q, neg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod, prod_fix;

  // Operand magnitudes; -2^(WIDTH-1) maps onto the unsigned value 2^(WIDTH-1).
  always_comb begin
    mag_a = (is_signed_i && op_a_i[WIDTH-1]) ? (~op_a_i + WIDTH'(1)) : op_a_i;
    mag_b = (is_signed_i && op_b_i[WIDTH-1]) ? (~op_b_i + WIDTH'(1)) : op_b_i;
  end

  // Datapath: conditional add with carry kept, and the signed-corrected product.
  always_comb begin
    sum      = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    prod     = {acc_q, mplier_q};
    prod_fix = neg_q ? (~prod + (2*WIDTH)'(1)) : prod;
  end

  // Next-state logic: flush aborts everything in flight without touching hi/lo.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    hi_d     = hi_q;
    lo_d     = lo_q;
    if (flush_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            mcand_d  = mag_a;
            mplier_d = mag_b;
            neg_d    = is_signed_i & (op_a_i[WIDTH-1] ^ op_b_i[WIDTH-1]);
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = S_CALC;
          end
        end
        S_CALC: begin
          acc_d    = sum[WIDTH:1];
          mplier_d = {sum[0], mplier_q[WIDTH-1:1]};
          if (cnt_q == LAST_ITER) begin
            cnt_d   = '0;
            state_d = S_FIX;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_FIX: begin
          hi_d    = prod_fix[2*WIDTH-1:WIDTH];
          lo_d    = prod_fix[WIDTH-1:0];
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State registers; reset discards any operation in progress.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy_o  = (state_q == S_CALC) || (state_q == S_FIX);
  assign done_o  = done_q;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;
  assign state_o = state_q;

endmodule
